fb_arbiter: RTL and testbench

Sequences and shares the single-port 4-bit framebuffer RAM between three requesters: video scanout (reads), a pixel writer (writes), and a built-in clear engine that fills the whole framebuffer with one colour. Sits between the `counts`/pixel-output path and the Gowin single-port RAM, and owns the RAM address, data and write-enable lines. Scanout always wins, so the composite output never misses a pixel.

---
 rtl/fb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fb_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares the single-port 4-bit framebuffer RAM between scanout reads, a pixel
// writer and a fill (clear) engine. Optional macro FB_WRITE_FIFO_EN adds a 4-deep write FIFO.
module fb_arbiter #(
  parameter int ADDR_W       = 16,
  parameter int FB_DEPTH     = 61440,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              video_req,
  input  logic [ADDR_W-1:0] video_addr,
  output logic [3:0]        video_pixel,
  output logic              video_valid,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [3:0]        wr_data,
  input  logic              clear_start,
  input  logic [3:0]        clear_color,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_ad,
  output logic [3:0]        ram_din,
  output logic              ram_wre,
  input  logic [3:0]        ram_dout,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    CLEAR = 2'd2
  } state_t;

  localparam int                CNT_W    = $clog2(READ_LATENCY + 2);
  localparam logic [CNT_W-1:0]  RD_START = CNT_W'(READ_LATENCY + 1);
  localparam logic [CNT_W-1:0]  RD_FIRE  = CNT_W'(2);
  localparam logic [CNT_W-1:0]  RD_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(FB_DEPTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  rd_cnt;
  logic [ADDR_W-1:0] clr_addr;
  logic [3:0]        clr_color;
  logic [3:0]        pix_q;

  logic              free_slot;
  logic              clr_issue;
  logic              clr_last;
  logic              busy_nxt;
  logic              rd_busy_nxt;
  logic              wr_go;
  logic [ADDR_W-1:0] wr_go_addr;
  logic [3:0]        wr_go_data;

  // rd_cnt counts down the READ_LATENCY+1 cycles after a request; the RAM is free only at zero.
  assign free_slot = !video_req && (rd_cnt == '0);
  assign dbg_state = state;

  // Data arrives from the RAM output register in the same cycle video_valid is high.
  assign video_pixel = video_valid ? ram_dout : pix_q;

  // Writer handshake: a write transfers in any cycle where wr_valid && wr_ready are both high;
  // the writer keeps wr_addr/wr_data stable while wr_valid waits for wr_ready.
`ifdef FB_WRITE_FIFO_EN
  logic [ADDR_W-1:0] fifo_addr [4];
  logic [3:0]        fifo_data [4];
  logic [1:0]        fifo_rd;
  logic [1:0]        fifo_wr;
  logic [2:0]        fifo_cnt;
  logic              fifo_push;

  assign wr_ready   = !reset && (fifo_cnt != 3'd4);
  assign fifo_push  = wr_valid && wr_ready;
  assign wr_go      = free_slot && !busy && (fifo_cnt != 3'd0);
  assign wr_go_addr = fifo_addr[fifo_rd];
  assign wr_go_data = fifo_data[fifo_rd];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_rd  <= 2'd0;
      fifo_wr  <= 2'd0;
      fifo_cnt <= 3'd0;
    end else begin
      if (fifo_push) fifo_wr <= fifo_wr + 2'd1;
      if (wr_go)     fifo_rd <= fifo_rd + 2'd1;
      case ({fifo_push, wr_go})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_addr[fifo_wr] <= wr_addr;
      fifo_data[fifo_wr] <= wr_data;
    end
  end
`else
  assign wr_ready   = !reset && free_slot && !busy;
  assign wr_go      = wr_valid && wr_ready;
  assign wr_go_addr = wr_addr;
  assign wr_go_data = wr_data;
`endif

  always_comb begin
    clr_issue   = free_slot && busy;
    clr_last    = (clr_addr == CLR_LAST);
    busy_nxt    = busy ? !(clr_issue && clr_last) : clear_start;
    rd_busy_nxt = video_req || (rd_cnt > RD_ONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      rd_cnt      <= '0;
      clr_addr    <= '0;
      clr_color   <= 4'd0;
      pix_q       <= 4'd0;
      busy        <= 1'b0;
      video_valid <= 1'b0;
      ram_ad      <= '0;
      ram_din     <= 4'd0;
      ram_wre     <= 1'b0;
    end else begin
      ram_wre     <= 1'b0;
      video_valid <= 1'b0;
      busy        <= busy_nxt;
      state       <= rd_busy_nxt ? READ : (busy_nxt ? CLEAR : IDLE);

      if (video_valid) pix_q <= ram_dout;

      if (video_req) begin
        // A request during an in-flight read restarts the countdown, dropping the older read.
        ram_ad <= video_addr;
        rd_cnt <= RD_START;
      end else if (rd_cnt != '0) begin
        rd_cnt      <= rd_cnt - RD_ONE;
        video_valid <= (rd_cnt == RD_FIRE);
      end else if (busy) begin
        ram_ad  <= clr_addr;
        ram_din <= clr_color;
        ram_wre <= 1'b1;
        if (!clr_last) clr_addr <= clr_addr + ADDR_ONE;
      end else if (wr_go) begin
        ram_ad  <= wr_go_addr;
        ram_din <= wr_go_data;
        ram_wre <= 1'b1;
      end

      if (clear_start && !busy) begin
        clr_addr  <= '0;
        clr_color <= clear_color;
      end
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// Bench for fb_arbiter: registered-output RAM model plus a cycle-level reference of the
// arbitration rules (read windows, clear sequence, writer slots) and a pixel scoreboard.
module tb_fb_arbiter;

  localparam int AW    = 16;
  localparam int DEPTH = 16;
  localparam int RL    = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          video_req = 1'b0;
  logic [AW-1:0] video_addr = '0;
  logic [3:0]    video_pixel;
  logic          video_valid;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [AW-1:0] wr_addr = '0;
  logic [3:0]    wr_data = 4'd0;
  logic          clear_start = 1'b0;
  logic [3:0]    clear_color = 4'd0;
  logic          busy;
  logic [AW-1:0] ram_ad;
  logic [3:0]    ram_din;
  logic          ram_wre;
  logic [3:0]    ram_dout = 4'd0;
  logic [1:0]    dbg_state;

  // ---------------- clock / DUT ----------------
  always #5 clk = ~clk;

  fb_arbiter #(.ADDR_W(AW), .FB_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset(reset),
    .video_req(video_req), .video_addr(video_addr),
    .video_pixel(video_pixel), .video_valid(video_valid),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .clear_start(clear_start), .clear_color(clear_color), .busy(busy),
    .ram_ad(ram_ad), .ram_din(ram_din), .ram_wre(ram_wre), .ram_dout(ram_dout),
    .dbg_state(dbg_state)
  );

  // Single-port RAM with address capture plus output register (2 edges to data).
  logic [3:0] mem [0:65535];
  logic [3:0] ram_stage = 4'd0;
  always @(posedge clk) begin
    if (ram_wre) mem[ram_ad] <= ram_din;
    ram_stage <= mem[ram_ad];
    ram_dout  <= ram_stage;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [3:0]    ref_mem [0:65535];
  logic [3:0]    exp_q[$];
  int            exp_t[$];
  int            cyc = 0;
  int            last_req = -100;
  logic          m_busy = 1'b0;
  int            clr_next = 0;
  logic [3:0]    clr_col = 4'd0;
  logic          e_wre = 1'b0;
  logic          e_rd = 1'b0;
  logic [AW-1:0] e_ad = '0;
  logic [3:0]    e_din = 4'd0;
  logic [3:0]    e_prev = 4'd0;
  logic [3:0]    held_pix = 4'd0;
  logic [3:0]    last_vpix = 4'd0;
  logic          obs_ready = 1'b0;
  int            wre_seen = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [3:0] d);
    e_wre  = 1'b1;
    e_ad   = a;
    e_din  = d;
    e_prev = ref_mem[a];
    ref_mem[a] = d;
  endtask

  // Called at posedge+1 with this cycle's inputs applied; checks at the negedge and
  // predicts what the RAM-side registers must show next cycle.
  task automatic step();
    logic b0, free, exp_vv;
    @(negedge clk);
    check("ram_wre", ram_wre, e_wre);
    if (e_wre) begin
      check("ram_ad_wr", ram_ad, e_ad);
      check("ram_din", ram_din, e_din);
    end
    if (e_rd) check("ram_ad_rd", ram_ad, e_ad);
    if (ram_wre) wre_seen++;
    exp_vv = (exp_t.size() > 0) && (exp_t[0] == cyc);
    check("video_valid", video_valid, exp_vv);
    if (exp_vv) begin
      held_pix = exp_q.pop_front();
      void'(exp_t.pop_front());
    end
    check("video_pixel", video_pixel, held_pix);
    if (video_valid) last_vpix = video_pixel;
    check("busy", busy, m_busy);
    b0   = m_busy;
    free = !video_req && (cyc > last_req + RL + 1);
    obs_ready = wr_ready;
    check("wr_ready", wr_ready, free && !b0);

    e_wre = 1'b0;
    e_rd  = 1'b0;
    if (video_req) begin
      exp_q.delete();
      exp_t.delete();
      exp_q.push_back(ref_mem[video_addr]);
      exp_t.push_back(cyc + RL + 1);
      last_req = cyc;
      e_rd = 1'b1;
      e_ad = video_addr;
    end else if (free && b0) begin
      issue(AW'(clr_next), clr_col);
      clr_next++;
      if (clr_next == DEPTH) m_busy = 1'b0;
    end else if (free && wr_valid) begin
      issue(wr_addr, wr_data);
    end
    if (clear_start && !b0) begin
      m_busy   = 1'b1;
      clr_next = 0;
      clr_col  = clear_color;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    video_req   = 1'b0;
    wr_valid    = 1'b0;
    clear_start = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    video_req   = 1'b0;
    wr_valid    = 1'b0;
    clear_start = 1'b0;
    #1;
    check("rst_video_valid", video_valid, 0);
    check("rst_video_pixel", video_pixel, 0);
    check("rst_ram_ad", ram_ad, 0);
    check("rst_ram_din", ram_din, 0);
    check("rst_ram_wre", ram_wre, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_state", dbg_state, 0);
    // A write announced for this cycle is cut off before the RAM edge.
    if (e_wre) ref_mem[e_ad] = e_prev;
    e_wre    = 1'b0;
    e_rd     = 1'b0;
    m_busy   = 1'b0;
    held_pix = 4'd0;
    last_req = -100;
    exp_q.delete();
    exp_t.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cnt;
    for (int i = 0; i < 65536; i++) begin
      mem[i]     = 4'd0;
      ref_mem[i] = 4'd0;
    end
    mem[16'h0105]     = 4'hA;
    ref_mem[16'h0105] = 4'hA;

    #2;
    do_reset();

    // Periodic scanout of a preloaded pixel.
    video_addr = 16'h0105;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 16; j++) begin
        video_req = (j == 0);
        step();
      end
    end
    video_req = 1'b0;
    check("scan_pixel", last_vpix, 4'hA);

    // Writer held while a read takes the RAM.
    video_req = 1'b1;
    video_addr = 16'h0105;
    wr_valid = 1'b1;
    wr_addr = 16'h0010;
    wr_data = 4'h7;
    cnt = 0;
    while (cnt < 20) begin
      step();
      video_req = 1'b0;
      if (obs_ready) break;
      cnt++;
    end
    check("wr_wait", cnt, RL + 2);
    wr_valid = 1'b0;
    idle(2);
    video_req = 1'b1;
    video_addr = 16'h0010;
    step();
    idle(4);
    check("rb_0010", last_vpix, 4'h7);

    // Clear with interleaved reads and an ignored second start.
    wre_seen = 0;
    clear_start = 1'b1;
    clear_color = 4'h3;
    step();
    clear_start = 1'b0;
    for (int j = 0; j < 60; j++) begin
      video_req   = (j < 30) && (j % 7 == 3);
      video_addr  = AW'(j % 16);
      clear_start = (j == 5);
      clear_color = 4'h5;
      step();
    end
    clear_start = 1'b0;
    video_req = 1'b0;
    check("clr_writes", wre_seen, DEPTH);
    check("clr_done_busy", busy, 0);
    for (int a = 0; a < DEPTH; a++) begin
      video_req = 1'b1;
      video_addr = AW'(a);
      step();
      idle(4);
      check("clr_rd", last_vpix, 4'h3);
    end

    // Reset in the middle of a clear, then in the middle of a read.
    clear_start = 1'b1;
    clear_color = 4'h9;
    step();
    idle(5);
    check("busy_mid_clear", busy, 1);
    do_reset();
    idle(6);
    video_req = 1'b1;
    video_addr = 16'h0105;
    step();
    idle(1);
    do_reset();
    idle(6);

    // Randomised traffic.
    for (int j = 0; j < 800; j++) begin
      video_req   = ($urandom_range(0, 3) == 0);
      video_addr  = AW'($urandom_range(0, 31));
      wr_valid    = ($urandom_range(0, 1) == 1);
      wr_addr     = AW'($urandom_range(0, 31));
      wr_data     = 4'($urandom_range(0, 15));
      clear_start = ($urandom_range(0, 99) == 0);
      clear_color = 4'($urandom_range(0, 15));
      step();
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
